// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared definitions for the APB UART receiver.
//   - Register offsets (decoded from paddr[3:2])
//   - Parity verify-mode encodings held in CTRL[2:1]
//   - Receive FSM state enum
//   - STATUS bit indices
//   - Parity helper functions used by the deframer
package uart_rx_pkg;

  // Register offsets as seen on paddr[3:2].
  localparam logic [1:0] RegRxData = 2'd0;
  localparam logic [1:0] RegStatus = 2'd1;
  localparam logic [1:0] RegCtrl   = 2'd2;

  // Verify modes; 2'b00 and 2'b11 both mean "no parity bit".
  localparam logic [1:0] VerifyNone = 2'b00;
  localparam logic [1:0] VerifyOdd  = 2'b01;
  localparam logic [1:0] VerifyEven = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } rx_state_e;

  // STATUS register bit positions.
  localparam int unsigned StatEmpty   = 0;
  localparam int unsigned StatFull    = 1;
  localparam int unsigned StatParity  = 2;
  localparam int unsigned StatFrame   = 3;
  localparam int unsigned StatOverrun = 4;

  function automatic logic verify_has_parity(input logic [1:0] verify);
    return (verify == VerifyOdd) || (verify == VerifyEven);
  endfunction

  // Odd mode wants an odd number of ones across data plus parity bit, even mode an even one.
  function automatic logic parity_mismatch(input logic [7:0] data, input logic pbit,
                                           input logic [1:0] verify);
    logic odd_total;
    odd_total = ^{data, pbit};
    case (verify)
      VerifyOdd:  return ~odd_total;
      VerifyEven: return odd_total;
      default:    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_apb_if.sv
// uart_rx_apb_if: APB bus bundle between the bridge (master) and the UART receiver (slave).
//   paddr   32  address; the slave decodes only [3:2]
//   psel     1  slave select
//   penable  1  access phase
//   pwrite   1  1 = write, 0 = read
//   pwdata  32  write data
//   prdata  32  read data, driven by the slave
interface uart_rx_apb_if;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;

  modport master (
    output paddr, psel, penable, pwrite, pwdata,
    input  prdata
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata,
    output prdata
  );
endinterface

// File: rtl/uart_rx_sfifo.sv
// uart_rx_sfifo: single-clock synchronous FIFO with show-ahead head.
//   clk_i    clock (rising edge)
//   rst_ni   asynchronous active-low reset; FIFO empty after reset
//   push_i   write wdata_i; accepted when not full, or when full and popping the same cycle
//   pop_i    drop the head entry; ignored when empty
//   wdata_i  write data
//   rdata_o  current head (valid only while !empty_o)
//   full_o   all Depth entries occupied
//   empty_o  no entries
// Depth must be a power of two; pointers carry one extra wrap bit to tell full from empty.
module uart_rx_sfifo #(
  parameter int unsigned Depth = 16,
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int unsigned AddrW = $clog2(Depth);

  logic [AddrW:0]   wptr_q, rptr_q;
  logic [Width-1:0] mem_q [Depth];
  logic             do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AddrW] != rptr_q[AddrW]) &&
                   (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);

  assign do_pop  = pop_i & ~empty_o;
  // A pop in the same cycle frees the slot the push lands in.
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AddrW-1:0]] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q[AddrW-1:0]];

endmodule

// File: rtl/uart_rx_apb.sv
// uart_rx_apb: UART receiver with an APB-readable receive FIFO.
//   pclk       system clock, rising edge
//   presetn    asynchronous active-low reset
//   apb        APB slave port (uart_rx_apb_if.slave); zero wait states, prdata combinational
//   uart_rx_i  asynchronous serial input, idle high
//   rx_irq_o   level interrupt while the FIFO holds data
// Registers: 0x0 RXDATA (read pops), 0x4 STATUS (bits [4:2] sticky, write 1 to clear),
//            0x8 CTRL {irq_en, verify[1:0], rx_en}, 0xC reads 0.
// Optional feature macro UART_RX_IRQ_EN: implements CTRL[3] and a registered rx_irq_o;
// without it rx_irq_o is tied low and CTRL[3] reads 0.
module uart_rx_apb
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 434,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic         pclk,
  input  logic         presetn,
  uart_rx_apb_if.slave apb,
  input  logic         uart_rx_i,
  output logic         rx_irq_o
);
  localparam int unsigned     CntW    = $clog2(CLK_DIV);
  localparam logic [CntW-1:0] CntLast = CntW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(CLK_DIV / 2 - 1);

  // APB decode
  logic [1:0] reg_addr;
  logic       apb_rd, apb_wr, rx_pop;

  assign reg_addr = apb.paddr[3:2];
  assign apb_rd   = apb.psel & apb.penable & ~apb.pwrite;
  assign apb_wr   = apb.psel & apb.penable & apb.pwrite;
  assign rx_pop   = apb_rd & (reg_addr == RegRxData);

  logic unused_apb;
  assign unused_apb = ^{apb.paddr[31:4], apb.paddr[1:0], apb.pwdata[31:5]};

  // Line synchronizer plus one more flop for falling-edge detection
  logic rx_meta_q, rx_sync_q, rx_prev_q, rx_fall;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx_i;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  assign rx_fall = rx_prev_q & ~rx_sync_q;

  // Control register
  logic       rx_en_q;
  logic [1:0] ctrl_verify_q;
  logic       irq_en_rd;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      rx_en_q       <= 1'b1;
      ctrl_verify_q <= VerifyNone;
    end else if (apb_wr && reg_addr == RegCtrl) begin
      rx_en_q       <= apb.pwdata[0];
      ctrl_verify_q <= apb.pwdata[2:1];
    end
  end

  // Receive FSM and datapath
  rx_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      bit_q;
  logic [7:0]      shift_q;
  logic [1:0]      verify_q;
  logic            parity_bad_q;
  logic            push_q;
  logic            half_tick, bit_tick;
  logic            data_sample, parity_sample, stop_sample;

  assign half_tick = (cnt_q == CntHalf);
  assign bit_tick  = (cnt_q == CntLast);

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) state_q <= StIdle;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (rx_en_q && rx_fall) state_d = StStart;
      // Line back high at mid-start means a glitch, not a character.
      StStart:  if (half_tick) state_d = rx_sync_q ? StIdle : StData;
      StData:   if (bit_tick && bit_q == 3'd7) begin
                  state_d = verify_has_parity(verify_q) ? StParity : StStop;
                end
      StParity: if (bit_tick) state_d = StStop;
      StStop:   if (bit_tick) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    // Disabling the receiver abandons any frame in flight.
    if (!rx_en_q) state_d = StIdle;
  end

  always_comb begin
    data_sample   = 1'b0;
    parity_sample = 1'b0;
    stop_sample   = 1'b0;
    if (rx_en_q) begin
      unique case (state_q)
        StData:   data_sample   = bit_tick;
        StParity: parity_sample = bit_tick;
        StStop:   stop_sample   = bit_tick;
        default: ;
      endcase
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      verify_q     <= VerifyNone;
      parity_bad_q <= 1'b0;
      push_q       <= 1'b0;
    end else begin
      if (state_q == StIdle || state_d != state_q || bit_tick) cnt_q <= '0;
      else                                                      cnt_q <= cnt_q + 1'b1;

      if (state_q != StData) bit_q <= '0;
      else if (data_sample)  bit_q <= bit_q + 3'd1;

      // LSB arrives first, so shift in from the top.
      if (data_sample) shift_q <= {rx_sync_q, shift_q[7:1]};

      if (state_q == StIdle && state_d == StStart) begin
        verify_q     <= ctrl_verify_q;
        parity_bad_q <= 1'b0;
      end else if (parity_sample) begin
        parity_bad_q <= parity_mismatch(shift_q, rx_sync_q, verify_q);
      end

      // shift_q stays stable while idle, so it still holds the character at push time.
      push_q <= stop_sample & rx_sync_q;
    end
  end

  // FIFO
  logic       fifo_full, fifo_empty, fifo_push;
  logic [7:0] fifo_head;
  logic       overrun_evt, frame_evt, parity_evt;

  assign fifo_push   = push_q & (~fifo_full | rx_pop);
  assign overrun_evt = push_q & fifo_full & ~rx_pop;
  assign frame_evt   = stop_sample & ~rx_sync_q;
  assign parity_evt  = stop_sample & rx_sync_q & parity_bad_q;

  uart_rx_sfifo #(
    .Depth (FIFO_DEPTH),
    .Width (8)
  ) u_fifo (
    .clk_i   (pclk),
    .rst_ni  (presetn),
    .push_i  (fifo_push),
    .pop_i   (rx_pop),
    .wdata_i (shift_q),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Sticky error flags; a new event in the same cycle as a clear wins.
  logic parity_err_q, frame_err_q, overrun_q;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      if (apb_wr && reg_addr == RegStatus) begin
        if (apb.pwdata[StatParity])  parity_err_q <= 1'b0;
        if (apb.pwdata[StatFrame])   frame_err_q  <= 1'b0;
        if (apb.pwdata[StatOverrun]) overrun_q    <= 1'b0;
      end
      if (parity_evt)  parity_err_q <= 1'b1;
      if (frame_evt)   frame_err_q  <= 1'b1;
      if (overrun_evt) overrun_q    <= 1'b1;
    end
  end

  // Interrupt
`ifdef UART_RX_IRQ_EN
  logic irq_en_q, irq_q;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (apb_wr && reg_addr == RegCtrl) irq_en_q <= apb.pwdata[3];
      irq_q <= irq_en_q & ~fifo_empty;
    end
  end

  assign irq_en_rd = irq_en_q;
  assign rx_irq_o  = irq_q;
`else
  assign irq_en_rd = 1'b0;
  assign rx_irq_o  = 1'b0;
`endif

  // Read mux
  always_comb begin
    apb.prdata = '0;
    if (apb_rd) begin
      case (reg_addr)
        RegRxData: apb.prdata = {24'd0, fifo_empty ? 8'd0 : fifo_head};
        RegStatus: apb.prdata = {27'd0, overrun_q, frame_err_q, parity_err_q,
                                 fifo_full, fifo_empty};
        RegCtrl:   apb.prdata = {28'd0, irq_en_rd, ctrl_verify_q, rx_en_q};
        default:   apb.prdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_apb.sv
module tb_uart_rx_apb;
  localparam int unsigned ClkDiv = 16;
  localparam int unsigned Depth  = 16;
`ifdef UART_RX_IRQ_EN
  localparam bit IrqImpl = 1'b1;
`else
  localparam bit IrqImpl = 1'b0;
`endif

  logic pclk    = 1'b0;
  logic presetn = 1'b0;
  logic uart_rx = 1'b1;
  logic rx_irq;

  uart_rx_apb_if apb ();

  uart_rx_apb #(
    .CLK_DIV    (ClkDiv),
    .FIFO_DEPTH (Depth)
  ) dut (
    .pclk      (pclk),
    .presetn   (presetn),
    .apb       (apb),
    .uart_rx_i (uart_rx),
    .rx_irq_o  (rx_irq)
  );

  always #5 pclk = ~pclk;

  int n_vec = 0;
  int n_err = 0;

  // Scoreboard of expected read data, filled by stimulus, drained by the monitor.
  logic [31:0] exp_val_q[$];
  string       exp_name_q[$];

  // Reference model: the receive FIFO as a byte queue plus flag/control bits.
  logic [7:0] m_fifo[$];
  bit         m_par, m_frame, m_ovr, m_en, m_irqen;
  bit [1:0]   m_verify;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge pclk) begin
    if (presetn && apb.psel && apb.penable && !apb.pwrite) begin
      if (exp_val_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_read: got 0x%08h, expected no read", apb.prdata);
      end else begin
        chk(exp_name_q.pop_front(), apb.prdata, exp_val_q.pop_front());
      end
    end
  end

  function automatic logic [31:0] m_status();
    return {27'd0, m_ovr, m_frame, m_par, m_fifo.size() == Depth, m_fifo.size() == 0};
  endfunction

  function automatic logic [31:0] m_ctrl();
    return {28'd0, IrqImpl & m_irqen, m_verify, m_en};
  endfunction

  function automatic logic m_irq();
    return IrqImpl && m_irqen && (m_fifo.size() != 0);
  endfunction

  task automatic m_reset();
    m_fifo.delete();
    m_par    = 0;
    m_frame  = 0;
    m_ovr    = 0;
    m_en     = 1;
    m_irqen  = 0;
    m_verify = 2'b00;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
    apb.paddr   = addr;
    apb.pwdata  = data;
    apb.pwrite  = 1'b1;
    apb.psel    = 1'b1;
    apb.penable = 1'b0;
    tick(1);
    apb.penable = 1'b1;
    tick(1);
    apb.psel    = 1'b0;
    apb.penable = 1'b0;
    case (addr[3:2])
      2'd1: begin
        if (data[2]) m_par   = 0;
        if (data[3]) m_frame = 0;
        if (data[4]) m_ovr   = 0;
      end
      2'd2: begin
        m_en     = data[0];
        m_verify = data[2:1];
        m_irqen  = data[3];
      end
      default: ;
    endcase
  endtask

  // Queue the model's expected read value, then issue the setup phase.
  task automatic read_setup(input logic [31:0] addr, input string name);
    logic [31:0] e;
    case (addr[3:2])
      2'd0:    e = (m_fifo.size() != 0) ? {24'd0, m_fifo.pop_front()} : 32'd0;
      2'd1:    e = m_status();
      2'd2:    e = m_ctrl();
      default: e = 32'd0;
    endcase
    exp_val_q.push_back(e);
    exp_name_q.push_back(name);
    apb.paddr   = addr;
    apb.pwrite  = 1'b0;
    apb.psel    = 1'b1;
    apb.penable = 1'b0;
    tick(1);
    apb.penable = 1'b1;
  endtask

  task automatic apb_read(input logic [31:0] addr, input string name);
    read_setup(addr, name);
    tick(1);
    apb.psel    = 1'b0;
    apb.penable = 1'b0;
  endtask

  task automatic drive_bit(input logic b);
    uart_rx = b;
    tick(ClkDiv);
  endtask

  // Send one frame; the parity bit (if the mode has one) is correct unless flip is set.
  task automatic send_frame(input logic [7:0] d, input bit stop, input bit flip);
    bit has_par, p;
    has_par = (m_verify == 2'b01) || (m_verify == 2'b10);
    p = ($countones(d) % 2 == 1) ? 1'b0 : 1'b1;
    if (m_verify == 2'b10) p = ~p;
    if (flip) p = ~p;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (has_par) drive_bit(p);
    drive_bit(stop);
    uart_rx = 1'b1;
    tick(2 * ClkDiv);
    if (m_en) begin
      if (!stop) m_frame = 1;
      else begin
        if (has_par && flip) m_par = 1;
        if (m_fifo.size() == Depth) m_ovr = 1;
        else m_fifo.push_back(d);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [1:0]   v;
    int         nchar;
    logic [7:0] d;
    bit         irq_before;

    apb.paddr   = '0;
    apb.pwdata  = '0;
    apb.pwrite  = 1'b0;
    apb.psel    = 1'b0;
    apb.penable = 1'b0;
    m_reset();
    tick(3);
    chk("reset_prdata", apb.prdata, 32'd0);
    chk("reset_irq", {31'd0, rx_irq}, 32'd0);
    presetn = 1'b1;
    tick(3);
    apb_read(32'h4, "reset_status");
    apb_read(32'h8, "reset_ctrl");
    apb_read(32'h0, "empty_rxdata");
    apb_read(32'hC, "reserved_read");

    // Plain character, no parity.
    send_frame(8'hA5, 1'b1, 1'b0);
    apb_read(32'h4, "a5_status");
    apb_read(32'h0, "a5_rxdata");
    apb_read(32'h4, "a5_status_after");

    // Odd mode with a wrong parity bit.
    apb_write(32'h8, 32'h3);
    apb_read(32'h8, "ctrl_odd");
    send_frame(8'h3C, 1'b1, 1'b1);
    apb_read(32'h4, "par_status");
    apb_read(32'h0, "par_rxdata");
    apb_write(32'h4, 32'h4);
    apb_read(32'h4, "par_cleared");

    // Bad stop bit.
    apb_write(32'h8, 32'h1);
    send_frame(8'h55, 1'b0, 1'b0);
    apb_read(32'h4, "frame_status");
    apb_write(32'h4, 32'h1C);
    apb_read(32'h4, "frame_cleared");

    // Receiver disabled: line activity ignored.
    apb_write(32'h8, 32'h0);
    send_frame(8'h99, 1'b1, 1'b0);
    apb_read(32'h4, "disabled_status");
    apb_write(32'h8, 32'h1);

    // Overflow: 17 characters into a 16-entry FIFO.
    for (int i = 0; i <= 16; i++) send_frame(8'(i), 1'b1, 1'b0);
    apb_read(32'h4, "ovr_status");
    for (int i = 0; i <= 16; i++) apb_read(32'h0, $sformatf("ovr_rxdata_%0d", i));
    apb_read(32'h4, "ovr_status_drained");
    apb_write(32'h4, 32'h1C);

    // Randomized characters, modes, parity errors and framing errors.
    for (int it = 0; it < 8; it++) begin
      v = 2'($urandom_range(0, 3));
      apb_write(32'h8, {29'd0, v, 1'b1});
      nchar = $urandom_range(1, 3);
      for (int c = 0; c < nchar; c++) begin
        d = 8'($urandom);
        send_frame(d, $urandom_range(0, 5) != 0, $urandom_range(0, 3) == 0);
      end
      apb_read(32'h4, $sformatf("rnd%0d_status", it));
      for (int c = 0; c <= nchar; c++) apb_read(32'h0, $sformatf("rnd%0d_rxdata", it));
      apb_write(32'h4, 32'h1C);
      apb_read(32'h4, $sformatf("rnd%0d_cleared", it));
    end
    apb_write(32'h8, 32'h1);

    // 4-cycle glitch on an idle line.
    uart_rx = 1'b0;
    tick(4);
    uart_rx = 1'b1;
    tick(2 * ClkDiv);
    apb_read(32'h4, "glitch_status");
    apb_read(32'h0, "glitch_rxdata");

    // Reset in the middle of a frame, with a character already buffered.
    apb_write(32'h8, 32'h9);
    send_frame(8'h42, 1'b1, 1'b0);
    chk("pre_reset_irq", {31'd0, rx_irq}, {31'd0, m_irq()});
    uart_rx = 1'b0;
    tick(3 * ClkDiv);
    presetn = 1'b0;
    #1;
    chk("midreset_prdata", apb.prdata, 32'd0);
    chk("midreset_irq", {31'd0, rx_irq}, 32'd0);
    uart_rx = 1'b1;
    tick(3);
    presetn = 1'b1;
    m_reset();
    tick(3);
    apb_read(32'h4, "postreset_status");
    apb_read(32'h8, "postreset_ctrl");
    send_frame(8'h5A, 1'b1, 1'b0);
    apb_read(32'h0, "postreset_rxdata");

    // Interrupt enable path and the timing of its fall after the emptying read.
    apb_write(32'h8, 32'h9);
    apb_read(32'h8, "irq_ctrl");
    chk("irq_idle", {31'd0, rx_irq}, 32'd0);
    send_frame(8'h81, 1'b1, 1'b0);
    irq_before = m_irq();
    chk("irq_after_rx", {31'd0, rx_irq}, {31'd0, irq_before});
    read_setup(32'h0, "irq_rxdata");
    chk("irq_access", {31'd0, rx_irq}, {31'd0, irq_before});
    tick(1);
    apb.psel    = 1'b0;
    apb.penable = 1'b0;
    chk("irq_pop_edge", {31'd0, rx_irq}, {31'd0, irq_before});
    tick(1);
    chk("irq_after_pop", {31'd0, rx_irq}, {31'd0, m_irq()});
    apb_read(32'h4, "irq_final_status");

    for (int i = 0; i < 10 && exp_val_q.size() != 0; i++) tick(1);
    if (exp_val_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_val_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
